divider: RTL and testbench

//   Sequential restoring unsigned divider, the inverse counterpart of the shift-add multiplier.

---
 rtl/divider.sv | 92 +++++++++
 tb/tb_divider.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Restoring unsigned divider: one quotient bit per clock, result ready N cycles after the start edge.
// start is accepted only while ready=1; requests made while busy are dropped.
module divider #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [N-1:0]  quo;
  logic [N-1:0]  rem;
  logic [N-1:0]  dvs;
  logic          dbz;

  logic          launch;
  logic          last;
  logic [N:0]    partial;
  logic          fits;
  logic [N-1:0]  rem_next;

  assign launch = (state == IDLE) && start;
  assign last   = (state == BUSY) && (count == CNT_LAST);

  // Trial subtraction of the divisor from the shifted partial remainder.
  // The remainder stays below a nonzero divisor, so the low N bits of the
  // difference are the full result; with a zero divisor nothing is subtracted.
  assign partial  = {rem, quo[N-1]};
  assign fits     = partial >= {1'b0, dvs};
  assign rem_next = fits ? (partial[N-1:0] - dvs) : partial[N-1:0];

  // Controller
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else if (launch) begin
      state <= BUSY;
    end else if (last) begin
      state <= IDLE;
    end
  end

  // Iteration counter
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (launch) begin
      count <= CNT_INIT;
    end else if (state == BUSY) begin
      count <= count - CNT_LAST;
    end
  end

  // Datapath: quotient bits shift in at the bottom as dividend bits shift out the top.
  always_ff @(posedge clock) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      dbz <= 1'b0;
    end else if (launch) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      dbz <= (divisor == '0);
    end else if (state == BUSY) begin
      quo <= {quo[N-2:0], fits};
      rem <= rem_next;
    end
  end

  assign ready       = (state == IDLE);
  assign quotient    = quo;
  assign remainder   = rem;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_divider.sv
// Bench for divider: table vectors, multi-cycle corner sequences, exhaustive 4-bit sweep, random 8-bit ops.
module tb_divider;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
  } vec_t;

  typedef struct {
    int q;
    int r;
    int dbz;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       start4;
  logic       ready4;
  logic [3:0] dividend4;
  logic [3:0] divisor4;
  logic [3:0] quotient4;
  logic [3:0] remainder4;
  logic       div_by_zero4;

  logic       start8;
  logic       ready8;
  logic [7:0] dividend8;
  logic [7:0] divisor8;
  logic [7:0] quotient8;
  logic [7:0] remainder8;
  logic       div_by_zero8;

  int n_cmp;
  int n_bad;
  exp_t sb4[$];
  exp_t sb8[$];
  vec_t tbl[6];

  divider #(.N(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .ready(ready4),
    .dividend(dividend4), .divisor(divisor4), .quotient(quotient4),
    .remainder(remainder4), .div_by_zero(div_by_zero4)
  );

  divider #(.N(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .ready(ready8),
    .dividend(dividend8), .divisor(divisor8), .quotient(quotient8),
    .remainder(remainder8), .div_by_zero(div_by_zero8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One division on the 4-bit unit; expected result goes through the scoreboard.
  task automatic op4(input int a, input int b, input int eq, input int er, input int ed,
                     input string tag);
    exp_t e;
    int n;
    e.q = eq; e.r = er; e.dbz = ed;
    sb4.push_back(e);
    @(negedge clock);
    dividend4 = 4'(a);
    divisor4  = 4'(b);
    start4    = 1'b1;
    @(negedge clock);
    start4    = 1'b0;
    check({tag, "_dbz_busy"}, int'(div_by_zero4), ed);
    n = 0;
    while (!ready4 && n < 20) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_latency"}, n, 4);
    e = sb4.pop_front();
    check({tag, "_quotient"}, int'(quotient4), e.q);
    check({tag, "_remainder"}, int'(remainder4), e.r);
    check({tag, "_dbz"}, int'(div_by_zero4), e.dbz);
    if (b != 0) begin
      check({tag, "_invariant"}, int'(quotient4) * b + int'(remainder4), a);
      check({tag, "_rem_lt_div"}, int'(int'(remainder4) < b), 1);
    end
  endtask

  task automatic op8(input int a, input int b, input string tag);
    exp_t e;
    int n;
    e.q   = (b == 0) ? 255 : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0) ? 1 : 0;
    sb8.push_back(e);
    @(negedge clock);
    dividend8 = 8'(a);
    divisor8  = 8'(b);
    start8    = 1'b1;
    @(negedge clock);
    start8    = 1'b0;
    n = 0;
    while (!ready8 && n < 40) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_latency"}, n, 8);
    e = sb8.pop_front();
    check({tag, "_quotient"}, int'(quotient8), e.q);
    check({tag, "_remainder"}, int'(remainder8), e.r);
    check({tag, "_dbz"}, int'(div_by_zero8), e.dbz);
  endtask

  initial begin
    exp_t e;
    int n;
    int bb_a[5];
    int bb_b[5];
    n_cmp = 0;
    n_bad = 0;

    tbl[0] = '{a: 13, b: 3, q: 4,  r: 1, dbz: 0};
    tbl[1] = '{a: 15, b: 1, q: 15, r: 0, dbz: 0};
    tbl[2] = '{a: 5,  b: 9, q: 0,  r: 5, dbz: 0};
    tbl[3] = '{a: 0,  b: 7, q: 0,  r: 0, dbz: 0};
    tbl[4] = '{a: 7,  b: 0, q: 15, r: 7, dbz: 1};
    tbl[5] = '{a: 6,  b: 2, q: 3,  r: 0, dbz: 0};
    bb_a = '{13, 15, 8, 9, 14};
    bb_b = '{3, 4, 3, 0, 5};

    reset = 1'b1;
    start4 = 1'b0; dividend4 = '0; divisor4 = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_ready", int'(ready4), 1);
    check("reset_quotient", int'(quotient4), 0);
    check("reset_remainder", int'(remainder4), 0);
    check("reset_dbz", int'(div_by_zero4), 0);
    check("reset_ready8", int'(ready8), 1);

    for (int i = 0; i < 6; i++) begin
      op4(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, $sformatf("tbl%0d", i));
    end

    // Start pulsed mid-operation with different operands must not disturb it.
    e.q = 4; e.r = 1; e.dbz = 0;
    sb4.push_back(e);
    @(negedge clock);
    dividend4 = 4'd13; divisor4 = 4'd3; start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    @(negedge clock);
    dividend4 = 4'd9; divisor4 = 4'd2; start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    n = 0;
    while (!ready4 && n < 20) begin
      n++;
      @(negedge clock);
    end
    check("ignore_ready_wait", int'(n < 20), 1);
    e = sb4.pop_front();
    check("ignore_quotient", int'(quotient4), e.q);
    check("ignore_remainder", int'(remainder4), e.r);
    dividend4 = 4'd2; divisor4 = 4'd1;
    repeat (3) @(negedge clock);
    check("hold_ready", int'(ready4), 1);
    check("hold_quotient", int'(quotient4), 4);
    check("hold_remainder", int'(remainder4), 1);

    // Reset during the second busy cycle aborts the division.
    @(negedge clock);
    dividend4 = 4'd13; divisor4 = 4'd3; start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready", int'(ready4), 1);
    check("abort_quotient", int'(quotient4), 0);
    check("abort_remainder", int'(remainder4), 0);
    check("abort_dbz", int'(div_by_zero4), 0);
    op4(14, 4, 3, 2, 0, "after_abort");

    // start held high: a new operand pair is presented at each ready cycle.
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      e.q   = (bb_b[i] == 0) ? 15 : bb_a[i] / bb_b[i];
      e.r   = (bb_b[i] == 0) ? bb_a[i] : bb_a[i] % bb_b[i];
      e.dbz = (bb_b[i] == 0) ? 1 : 0;
      sb4.push_back(e);
      dividend4 = 4'(bb_a[i]);
      divisor4  = 4'(bb_b[i]);
      start4    = 1'b1;
      @(negedge clock);
      n = 0;
      while (!ready4 && n < 20) begin
        n++;
        @(negedge clock);
      end
      check($sformatf("b2b%0d_gap", i), n + 1, 5);
      e = sb4.pop_front();
      check($sformatf("b2b%0d_quotient", i), int'(quotient4), e.q);
      check($sformatf("b2b%0d_remainder", i), int'(remainder4), e.r);
      check($sformatf("b2b%0d_dbz", i), int'(div_by_zero4), e.dbz);
    end
    start4 = 1'b0;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(a, b, (b == 0) ? 15 : a / b, (b == 0) ? a : a % b, (b == 0) ? 1 : 0,
            $sformatf("sweep_%0d_%0d", a, b));
      end
    end

    op8(255, 0, "n8_div0");
    op8(255, 1, "n8_max");
    op8(3, 200, "n8_small");
    for (int i = 0; i < 150; i++) begin
      op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $sformatf("n8_rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
